// File: rtl/nn_mul_share_arb.sv
// Round-robin arbiter that shares one unsigned multiplier among NUM_REQ
// requesters. There are two pipeline stages: S1 holds the granted operands and
// S2 holds the registered product. Each result is tagged with its requester index.
module nn_mul_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 7,
    parameter int B_WIDTH  = 11,
    parameter int P_WIDTH  = 17,
    parameter int ID_WIDTH = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]    req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [P_WIDTH-1:0]            rsp_data,
    output logic                          rsp_ovf
);

    localparam int FULL_W = A_WIDTH + B_WIDTH;

    // Full-width unsigned product of one operand pair.
    function automatic logic [FULL_W-1:0] mul_full(input logic [A_WIDTH-1:0] a,
                                                   input logic [B_WIDTH-1:0] b);
        return FULL_W'(a) * FULL_W'(b);
    endfunction

    // Low P_WIDTH bits of the product (wrap-around, no saturation).
    function automatic logic [P_WIDTH-1:0] trunc_prod(input logic [FULL_W-1:0] p);
        return p[P_WIDTH-1:0];
    endfunction

    // Flags any product bits that are dropped by truncation.
    function automatic logic ovf_prod(input logic [FULL_W-1:0] p);
        return |p[FULL_W-1:P_WIDTH];
    endfunction

    // Arbitration state and S1 registers.
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                vld_p1_q;
    logic [ID_WIDTH-1:0] id_p1_q;
    logic [A_WIDTH-1:0]  a_p1_q;
    logic [B_WIDTH-1:0]  b_p1_q;

    // S2 registers. These drive the response channel directly.
    logic                rsp_valid_q;
    logic [ID_WIDTH-1:0] rsp_id_q;
    logic [P_WIDTH-1:0]  rsp_data_q;
    logic                rsp_ovf_q;

    logic                s1_free, s2_free;
    logic                grant_vld, accept;
    logic [ID_WIDTH-1:0] grant_id;
    logic [A_WIDTH-1:0]  a_sel;
    logic [B_WIDTH-1:0]  b_sel;
    logic [FULL_W-1:0]   prod_p1;

    // S2 can take new data when it is empty or being drained this cycle.
    // S1 can take new data under the same condition one stage further back.
    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_free = !vld_p1_q || s2_free;

    // Round-robin search. The winner is the lowest valid index at or above
    // rr_ptr. If there is none, the search wraps to the lowest valid index overall.
    always_comb begin
        logic                hi_found, lo_found;
        logic [ID_WIDTH-1:0] hi_id, lo_id;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = ID_WIDTH'(i);
            end
            if (req_valid[i] && !hi_found && (i >= int'(rr_ptr_q))) begin
                hi_found = 1'b1;
                hi_id    = ID_WIDTH'(i);
            end
        end
        grant_vld = lo_found;
        grant_id  = hi_found ? hi_id : lo_id;
    end

    // Select the winning requester's operands from the packed buses.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                a_sel = req_a[i*A_WIDTH +: A_WIDTH];
                b_sel = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Drive a one-hot ready to the winner when S1 can accept.
    // Ready is held low while the block is in reset.
    always_comb begin
        req_ready = '0;
        if (ap_rst_n && grant_vld && s1_free) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    assign accept   = ap_rst_n && grant_vld && s1_free;
    assign rr_ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);

    // ---- S0 -> S1 boundary: grant, pointer update, operand capture ----

    // S1 valid and the round-robin pointer: refill whenever S1 frees up.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            vld_p1_q <= 1'b0;
            rr_ptr_q <= '0;
        end else if (s1_free) begin
            vld_p1_q <= accept;
            if (accept) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    // S1 operands and tag: captured only on an accepted request.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            id_p1_q <= grant_id;
            a_p1_q  <= a_sel;
            b_p1_q  <= b_sel;
        end
    end

    // ---- S1 -> S2 boundary: multiply (the critical path) and register the result ----

    assign prod_p1 = mul_full(a_p1_q, b_p1_q);

    // S2 result register: loads whenever it is free and holds under backpressure.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else if (s2_free) begin
            rsp_valid_q <= vld_p1_q;
            rsp_id_q    <= id_p1_q;
            rsp_data_q  <= trunc_prod(prod_p1);
            rsp_ovf_q   <= ovf_prod(prod_p1);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule
